ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage RISC-V pipeline, directly downstream of the ID/EX pipeline register. It resolves operand forwarding, decodes ALU control from ALUOp/funct, and computes the ALU result, using a 32-cycle iterative multiplier for `mul`. It then registers results and control into the EX/MEM pipeline register. It raises `ex_stall_o` while a multiply occupies EX; the top level ORs it into the hold input of PC, IF/ID and ID/EX.

## Interface
- No parameters.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `mem_stall_i` in 1: data-memory stall; EX/MEM register holds while high.
- `RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i` in 1 each: control from ID/EX.
- `ALUOp_i` in 2: 00 add, 10 R-type, 11 I-type, 01 reserved (treated as add).
- `rs1_data_i, rs2_data_i, imm_i` in 32: operands from ID/EX.
- `rs1_addr_i, rs2_addr_i, rd_addr_i` in 5: register addresses from ID/EX.
- `funct_i` in 10: {funct7, funct3}.
- `wb_RegWrite_i` in 1, `wb_rd_addr_i` in 5, `wb_data_i` in 32: MEM/WB writeback for forwarding.
- `RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o` out 1 each: registered EX/MEM control.
- `ALU_result_o` out 32: registered result (or memory address).
- `rs2_data_o` out 32: registered forwarded store data.
- `rd_addr_o` out 5: registered destination.
- `ex_stall_o` out 1: combinational; hold upstream stages.

## Operation
- Forwarding, per operand A (rs1) and B (rs2):
  - EX/MEM hit first: `RegWrite_o` && `rd_addr_o`!=0 && match -> `ALU_result_o`.
  - Otherwise WB hit: `wb_RegWrite_i` && `wb_rd_addr_i`!=0 && match -> `wb_data_i`.
  - Otherwise the ID/EX data.
  - Load-use hazards are resolved upstream and are not handled here.
- Second ALU input is `imm_i` if `ALUSrc_i`, else forwarded B. Store data is always forwarded B.
- Decode:
  - ALUOp 00/01: add.
  - ALUOp 10: funct 0000000_000 add; 0100000_000 sub; 0000000_111 and; 0000000_100 xor; 0000000_001 sll (shift amount B[4:0]); 0000001_000 mul.
  - ALUOp 11: funct3 000 addi; funct3 101 srai (arithmetic, shift amount imm[4:0]).
  - Any other code: result 0.
- All arithmetic is 32-bit, wraps modulo 2^32, and sets no flags. `mul` returns the low 32 bits of the product (sign-agnostic).
- Multiplier FSM:
  - IDLE: if a mul is decoded and `mem_stall_i`=0, latch the forwarded A and B, clear the 32-bit accumulator, counter=0, go to BUSY.
  - BUSY: each cycle, if multiplier LSB=1 then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. Go to DONE when counter reaches 31.
  - DONE: result = acc. Go to IDLE when `mem_stall_i`=0, otherwise stay in DONE. Mul decode is ignored in DONE.
- `ex_stall_o` = (IDLE && mul decoded) || BUSY.
- EX/MEM register:
  - `rst_i`: all outputs cleared to 0.
  - Else if `mem_stall_i`: hold.
  - Else if `ex_stall_o`: load a bubble (all four control bits 0; data fields don't-care, driven 0).
  - Else: load the current result, control and addresses.

## Timing
- Non-mul instruction: 1-cycle latency; outputs valid the cycle after the instruction is in EX.
- mul entering EX at cycle T:
  - `ex_stall_o`=1 during T..T+32.
  - DONE at T+33 with stall=0; EX/MEM captures the product at the T+33 edge, and ID/EX advances at the same edge.
  - Total EX occupancy 34 cycles, with 33 bubbles inserted into MEM.
- Operands are latched at T, so EX/MEM draining to bubbles does not corrupt the multiply.
- `mem_stall_i` during BUSY: the counter keeps running and EX/MEM holds. During DONE, DONE is held until the stall drops.
- `mem_stall_i`=1 with a mul in IDLE: the multiply does not start; `ex_stall_o` is still 1.
- Reset mid-multiply: FSM to IDLE, counter 0, `ex_stall_o`=0 the next cycle.
- Reset values: every registered output 0, FSM IDLE.
- Writes to x0 are never forwarded, even if RegWrite is set.

## Test plan
- Assert `rst_i` 2 cycles with random inputs -> all outputs 0, `ex_stall_o`=0, and the first post-reset add of 5+7 gives `ALU_result_o`=12 one cycle later.
- Back-to-back `add x1=3+4` then `sub x2=x1-1` with stale rs1_data=0 -> second result 6 (EX/MEM forward).
- x3 matches both EX/MEM (value 9) and WB (value 2) -> EX/MEM wins, operand=9. With rd=x0 in EX/MEM, WB is used.
- `srai` of 0xF0000000 by 4 -> 0xFF000000. `sll` of 1 by B=0x23 -> 0x00000008.
- `mul` 7 × 0xFFFFFFFD -> 0xFFFFFFEB captured at T+33 edge, `ex_stall_o` high exactly T..T+32, RegWrite_o=0 for 33 cycles before.
- `mem_stall_i` held from T+30 to T+36 during mul -> FSM waits in DONE, result appears the edge after stall drops, and the mul starts no second time.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle of all non-clock/reset signals of the execute stage.
//   *_i signals : ID/EX operands and control, MEM/WB writeback, memory stall
//   *_o signals : registered EX/MEM outputs, combinational upstream hold,
//                 and the multiplier FSM state for observation
// Handshake: there is no valid/ready pair here. The stage advances every
// cycle unless held. mem_stall_i freezes the EX/MEM register. ex_stall_o asks
// the upstream stages to hold the instruction currently presented to EX.
// modport master drives the *_i side; modport slave is the execute stage.
interface ex_stage_if;
  logic        mem_stall_i;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [4:0]  rd_addr_i;
  logic [9:0]  funct_i;
  logic        wb_RegWrite_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_data_i;

  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic [31:0] ALU_result_o;
  logic [31:0] rs2_data_o;
  logic [4:0]  rd_addr_o;
  logic        ex_stall_o;
  logic [1:0]  mul_state_o;

  modport master (
    output mem_stall_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
           ALUSrc_i, ALUOp_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i,
           rs2_addr_i, rd_addr_i, funct_i, wb_RegWrite_i, wb_rd_addr_i,
           wb_data_i,
    input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALU_result_o,
           rs2_data_o, rd_addr_o, ex_stall_o, mul_state_o
  );

  modport slave (
    input  mem_stall_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
           ALUSrc_i, ALUOp_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i,
           rs2_addr_i, rd_addr_i, funct_i, wb_RegWrite_i, wb_rd_addr_i,
           wb_data_i,
    output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALU_result_o,
           rs2_data_o, rd_addr_o, ex_stall_o, mul_state_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage RISC-V pipeline.
// Resolves operand forwarding (EX/MEM first, then MEM/WB), decodes the ALU
// operation from ALUOp/funct, computes the result (mul via a 32-iteration
// shift-add multiplier) and registers result + control into EX/MEM.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : ex_stage_if.slave (ID/EX inputs, WB forwarding, EX/MEM outputs,
//            ex_stall_o upstream hold, mul_state_o FSM state)
module ex_stage (
  input logic     clk_i,
  input logic     rst_i,
  ex_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t  state_q, state_d;
  logic [4:0]  mul_cnt;
  logic [31:0] mul_acc, mul_mcand, mul_mplier;
  logic        mul_start, mul_busy, ex_stall;

  // ---------------- forwarding ----------------
  logic        fwd_a_ex, fwd_a_wb, fwd_b_ex, fwd_b_wb;
  logic [31:0] op_a, op_b, alu_b, alu_res;
  logic        is_mul;

  assign fwd_a_ex = bus.RegWrite_o && (bus.rd_addr_o != 5'd0) &&
                    (bus.rd_addr_o == bus.rs1_addr_i);
  assign fwd_a_wb = bus.wb_RegWrite_i && (bus.wb_rd_addr_i != 5'd0) &&
                    (bus.wb_rd_addr_i == bus.rs1_addr_i);
  assign fwd_b_ex = bus.RegWrite_o && (bus.rd_addr_o != 5'd0) &&
                    (bus.rd_addr_o == bus.rs2_addr_i);
  assign fwd_b_wb = bus.wb_RegWrite_i && (bus.wb_rd_addr_i != 5'd0) &&
                    (bus.wb_rd_addr_i == bus.rs2_addr_i);

  always_comb begin
    if (fwd_a_ex)      op_a = bus.ALU_result_o;
    else if (fwd_a_wb) op_a = bus.wb_data_i;
    else               op_a = bus.rs1_data_i;
    if (fwd_b_ex)      op_b = bus.ALU_result_o;
    else if (fwd_b_wb) op_b = bus.wb_data_i;
    else               op_b = bus.rs2_data_i;
  end

  assign alu_b  = bus.ALUSrc_i ? bus.imm_i : op_b;
  assign is_mul = (bus.ALUOp_i == 2'b10) && (bus.funct_i == 10'b0000001_000);

  // ---------------- ALU ----------------
  // The mul arm returns the accumulator; it is only captured in DONE, where
  // the accumulator holds the finished product.
  always_comb begin
    alu_res = 32'd0;
    case (bus.ALUOp_i)
      2'b00, 2'b01: alu_res = op_a + alu_b;
      2'b10: begin
        case (bus.funct_i)
          10'b0000000_000: alu_res = op_a + alu_b;
          10'b0100000_000: alu_res = op_a - alu_b;
          10'b0000000_111: alu_res = op_a & alu_b;
          10'b0000000_100: alu_res = op_a ^ alu_b;
          10'b0000000_001: alu_res = op_a << alu_b[4:0];
          10'b0000001_000: alu_res = mul_acc;
          default:         alu_res = 32'd0;
        endcase
      end
      2'b11: begin
        case (bus.funct_i[2:0])
          3'b000:  alu_res = op_a + alu_b;
          3'b101:  alu_res = $signed(op_a) >>> bus.imm_i[4:0];
          default: alu_res = 32'd0;
        endcase
      end
      default: alu_res = 32'd0;
    endcase
  end

  // ---------------- multiplier FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (is_mul && !bus.mem_stall_i) state_d = S_BUSY;
      S_BUSY:  if (mul_cnt == 5'd31)           state_d = S_DONE;
      S_DONE:  if (!bus.mem_stall_i)           state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ex_stall  = ((state_q == S_IDLE) && is_mul) || (state_q == S_BUSY);
    mul_start = (state_q == S_IDLE) && is_mul && !bus.mem_stall_i;
    mul_busy  = (state_q == S_BUSY);
  end

  // Operands are latched at start, so later forwarding changes (EX/MEM
  // draining to bubbles) cannot disturb the multiply.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_cnt    <= 5'd0;
      mul_acc    <= 32'd0;
      mul_mcand  <= 32'd0;
      mul_mplier <= 32'd0;
    end else if (mul_start) begin
      mul_cnt    <= 5'd0;
      mul_acc    <= 32'd0;
      mul_mcand  <= op_a;
      mul_mplier <= op_b;
    end else if (mul_busy) begin
      if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 5'd1;
    end
  end

  assign bus.ex_stall_o  = ex_stall;
  assign bus.mul_state_o = state_q;

  // ---------------- EX/MEM register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.RegWrite_o   <= 1'b0;
      bus.MemtoReg_o   <= 1'b0;
      bus.MemRead_o    <= 1'b0;
      bus.MemWrite_o   <= 1'b0;
      bus.ALU_result_o <= 32'd0;
      bus.rs2_data_o   <= 32'd0;
      bus.rd_addr_o    <= 5'd0;
    end else if (bus.mem_stall_i) begin
      // hold
    end else if (ex_stall) begin
      bus.RegWrite_o   <= 1'b0;
      bus.MemtoReg_o   <= 1'b0;
      bus.MemRead_o    <= 1'b0;
      bus.MemWrite_o   <= 1'b0;
      bus.ALU_result_o <= 32'd0;
      bus.rs2_data_o   <= 32'd0;
      bus.rd_addr_o    <= 5'd0;
    end else begin
      bus.RegWrite_o   <= bus.RegWrite_i;
      bus.MemtoReg_o   <= bus.MemtoReg_i;
      bus.MemRead_o    <= bus.MemRead_i;
      bus.MemWrite_o   <= bus.MemWrite_i;
      bus.ALU_result_o <= alu_res;
      bus.rs2_data_o   <= op_b;
      bus.rd_addr_o    <= bus.rd_addr_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. Directed scenarios followed
// by randomized instruction traffic, compared cycle by cycle against a
// behavioural model built from the instruction semantics.
module tb_ex_stage;

  logic clk;
  logic rst;
  ex_stage_if bus ();

  ex_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [72:0] exp_q[$];

  // model EX/MEM contents
  logic        m_rw, m_mtr, m_mr, m_mw;
  logic [31:0] m_res, m_rs2;
  logic [4:0]  m_rd;
  // model multiply progress
  bit          m_started;
  int          m_cycles;
  logic [31:0] m_prod;
  bit          m_stall;
  bit          obs_stall;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op,
                                          input logic [9:0] fn,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] imm);
    logic signed [31:0] sa;
    sa = a;
    if (op == 2'b00 || op == 2'b01) return a + b;
    if (op == 2'b10) begin
      if (fn == 10'b0000000_000) return a + b;
      if (fn == 10'b0100000_000) return a - b;
      if (fn == 10'b0000000_111) return a & b;
      if (fn == 10'b0000000_100) return a ^ b;
      if (fn == 10'b0000000_001) return a << b[4:0];
      return 32'd0;
    end
    if (fn[2:0] == 3'b000) return a + b;
    if (fn[2:0] == 3'b101) return sa >>> imm[4:0];
    return 32'd0;
  endfunction

  // One clock cycle with the inputs currently driven. Called just after a
  // negedge; checks ex_stall_o before the edge and EX/MEM after it.
  task automatic cycle();
    logic [31:0] a, b, bsel, res;
    bit          mul, done;
    logic [72:0] e;
    #1;
    a = (m_rw && m_rd != 0 && m_rd == bus.rs1_addr_i) ? m_res :
        (bus.wb_RegWrite_i && bus.wb_rd_addr_i != 0 &&
         bus.wb_rd_addr_i == bus.rs1_addr_i) ? bus.wb_data_i : bus.rs1_data_i;
    b = (m_rw && m_rd != 0 && m_rd == bus.rs2_addr_i) ? m_res :
        (bus.wb_RegWrite_i && bus.wb_rd_addr_i != 0 &&
         bus.wb_rd_addr_i == bus.rs2_addr_i) ? bus.wb_data_i : bus.rs2_data_i;
    bsel = bus.ALUSrc_i ? bus.imm_i : b;
    mul  = (bus.ALUOp_i == 2'b10) && (bus.funct_i == 10'b0000001_000);
    done = m_started && (m_cycles >= 32);
    if (!m_started)     m_stall = mul;
    else                m_stall = !done;
    res = done ? m_prod : ref_alu(bus.ALUOp_i, bus.funct_i, a, bsel, bus.imm_i);
    obs_stall = bus.ex_stall_o;
    if (!rst) chk("ex_stall_o", {31'd0, bus.ex_stall_o}, {31'd0, m_stall});
    @(posedge clk);
    if (rst) begin
      {m_rw, m_mtr, m_mr, m_mw} = 4'd0;
      m_res = 0; m_rs2 = 0; m_rd = 0;
      m_started = 0; m_cycles = 0;
    end else begin
      if (!m_started && mul && !bus.mem_stall_i) begin
        m_started = 1; m_cycles = 0; m_prod = a * b;
      end else if (m_started && !done) begin
        m_cycles++;
      end else if (done && !bus.mem_stall_i) begin
        m_started = 0;
      end
      if (bus.mem_stall_i) begin
      end else if (m_stall) begin
        {m_rw, m_mtr, m_mr, m_mw} = 4'd0;
        m_res = 0; m_rs2 = 0; m_rd = 0;
      end else begin
        {m_rw, m_mtr, m_mr, m_mw} = {bus.RegWrite_i, bus.MemtoReg_i,
                                     bus.MemRead_i, bus.MemWrite_i};
        m_res = res; m_rs2 = b; m_rd = bus.rd_addr_i;
      end
    end
    exp_q.push_back({m_rw, m_mtr, m_mr, m_mw, m_res, m_rs2, m_rd});
    @(negedge clk);
    e = exp_q.pop_front();
    chk("ctrl_o", {28'd0, bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o,
                   bus.MemWrite_o}, {28'd0, e[72:69]});
    chk("ALU_result_o", bus.ALU_result_o, e[68:37]);
    chk("rs2_data_o", bus.rs2_data_o, e[36:5]);
    chk("rd_addr_o", {27'd0, bus.rd_addr_o}, {27'd0, e[4:0]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [1:0] op, input logic [9:0] fn,
                        input logic src, input logic [4:0] ra,
                        input logic [31:0] da, input logic [4:0] rb,
                        input logic [31:0] db, input logic [31:0] imm,
                        input logic [4:0] rd, input logic rw);
    bus.ALUOp_i = op;   bus.funct_i = fn;   bus.ALUSrc_i = src;
    bus.rs1_addr_i = ra; bus.rs1_data_i = da;
    bus.rs2_addr_i = rb; bus.rs2_data_i = db;
    bus.imm_i = imm;    bus.rd_addr_i = rd; bus.RegWrite_i = rw;
    bus.MemtoReg_i = 0; bus.MemRead_i = 0;  bus.MemWrite_i = 0;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd,
                        input logic [31:0] d);
    bus.wb_RegWrite_i = en; bus.wb_rd_addr_i = rd; bus.wb_data_i = d;
  endtask

  function automatic logic [31:0] rand_data();
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40));
    return $urandom;
  endfunction

  task automatic rand_instr();
    logic [9:0] fn;
    logic [1:0] op;
    logic       src;
    src = 0;
    case ($urandom_range(0, 11))
      0:  begin op = 2'b00; fn = 10'($urandom); src = 1'($urandom); end
      1:  begin op = 2'b01; fn = 10'($urandom); end
      2:  begin op = 2'b10; fn = 10'b0000000_000; end
      3:  begin op = 2'b10; fn = 10'b0100000_000; end
      4:  begin op = 2'b10; fn = 10'b0000000_111; end
      5:  begin op = 2'b10; fn = 10'b0000000_100; end
      6:  begin op = 2'b10; fn = 10'b0000000_001; end
      7:  begin op = 2'b10; fn = 10'b0000001_000; end
      8:  begin op = 2'b11; fn = 10'b0000000_000; src = 1; end
      9:  begin op = 2'b11; fn = 10'b0100000_101; src = 1; end
      10: begin op = 2'b10; fn = 10'b0000000_010; end
      default: begin op = 2'b11; fn = 10'b0000000_011; src = 1; end
    endcase
    set_op(op, fn, src, 5'($urandom_range(0, 3)), rand_data(),
           5'($urandom_range(0, 3)), rand_data(), rand_data(),
           5'($urandom_range(0, 3)), 1'($urandom));
    bus.MemtoReg_i = 1'($urandom);
    bus.MemRead_i  = 1'($urandom);
    bus.MemWrite_i = 1'($urandom);
  endtask

  task automatic rand_wb();
    set_wb(1'($urandom), 5'($urandom_range(0, 3)), rand_data());
  endtask

  // ---------------- stimulus ----------------
  localparam logic [9:0] F_ADD = 10'b0000000_000;
  localparam logic [9:0] F_SUB = 10'b0100000_000;
  localparam logic [9:0] F_SLL = 10'b0000000_001;
  localparam logic [9:0] F_MUL = 10'b0000001_000;
  localparam logic [9:0] F_SRAI = 10'b0100000_101;

  initial begin
    int stalls, bubbles;
    bit hold;
    {m_rw, m_mtr, m_mr, m_mw} = 4'd0;
    m_res = 0; m_rs2 = 0; m_rd = 0; m_started = 0; m_cycles = 0; m_prod = 0;
    bus.mem_stall_i = 0;
    rst = 1;
    rand_instr(); rand_wb();
    @(negedge clk);

    // reset with random inputs for two cycles
    for (int i = 0; i < 2; i++) begin
      rand_instr(); rand_wb(); bus.mem_stall_i = 1'($urandom);
      cycle();
    end
    rst = 0; bus.mem_stall_i = 0;
    chk("rst_ALU_result", bus.ALU_result_o, 32'd0);
    chk("rst_RegWrite", {31'd0, bus.RegWrite_o}, 32'd0);
    set_op(2'b00, F_ADD, 0, 5'd10, 32'd5, 5'd11, 32'd7, 0, 5'd12, 1);
    set_wb(0, 0, 0);
    chk("post_rst_stall", {31'd0, bus.ex_stall_o}, 32'd0);
    cycle();
    chk("add_5_7", bus.ALU_result_o, 32'd12);

    // EX/MEM forwarding: add x1=3+4, then sub x2=x1-1 with stale rs1 data
    set_op(2'b10, F_ADD, 0, 5'd20, 32'd3, 5'd21, 32'd4, 0, 5'd1, 1);
    cycle();
    set_op(2'b10, F_SUB, 0, 5'd1, 32'd0, 5'd22, 32'd1, 0, 5'd2, 1);
    cycle();
    chk("fwd_exmem_sub", bus.ALU_result_o, 32'd6);

    // priority: x3 in EX/MEM (9) and WB (2)
    set_op(2'b10, F_ADD, 0, 5'd20, 32'd9, 5'd21, 32'd0, 0, 5'd3, 1);
    cycle();
    set_op(2'b10, F_ADD, 0, 5'd3, 32'd100, 5'd21, 32'd0, 0, 5'd4, 1);
    set_wb(1, 5'd3, 32'd2);
    cycle();
    chk("fwd_priority", bus.ALU_result_o, 32'd9);
    set_op(2'b10, F_ADD, 0, 5'd20, 32'd9, 5'd21, 32'd0, 0, 5'd0, 1);
    set_wb(0, 0, 0);
    cycle();
    set_op(2'b10, F_ADD, 0, 5'd3, 32'd100, 5'd21, 32'd0, 0, 5'd4, 1);
    set_wb(1, 5'd3, 32'd2);
    cycle();
    chk("fwd_wb_x0_exmem", bus.ALU_result_o, 32'd2);
    // x0 is never forwarded from WB either
    set_op(2'b10, F_ADD, 0, 5'd0, 32'd0, 5'd21, 32'd1, 0, 5'd5, 1);
    set_wb(1, 5'd0, 32'd55);
    cycle();
    chk("no_fwd_x0", bus.ALU_result_o, 32'd1);
    set_wb(0, 0, 0);

    // shifts
    set_op(2'b11, F_SRAI, 1, 5'd20, 32'hF000_0000, 5'd21, 0, 32'h0000_0404,
           5'd6, 1);
    cycle();
    chk("srai", bus.ALU_result_o, 32'hFF00_0000);
    set_op(2'b10, F_SLL, 0, 5'd20, 32'd1, 5'd21, 32'h23, 0, 5'd7, 1);
    cycle();
    chk("sll", bus.ALU_result_o, 32'h0000_0008);

    // mul 7 * 0xFFFFFFFD, held in ID/EX for its whole occupancy
    set_op(2'b10, F_MUL, 0, 5'd10, 32'd7, 5'd11, 32'hFFFF_FFFD, 0, 5'd8, 1);
    stalls = 0; bubbles = 0;
    for (int i = 0; i < 34; i++) begin
      cycle();
      if (obs_stall) stalls++;
      if (i < 33 && !bus.RegWrite_o) bubbles++;
    end
    chk("mul_product", bus.ALU_result_o, 32'hFFFF_FFEB);
    chk("mul_RegWrite", {31'd0, bus.RegWrite_o}, 32'd1);
    chk("mul_stall_cycles", stalls, 33);
    chk("mul_bubbles", bubbles, 33);
    set_op(2'b10, F_ADD, 0, 5'd8, 32'd0, 5'd21, 32'd1, 0, 5'd9, 1);
    cycle();
    chk("fwd_after_mul", bus.ALU_result_o, 32'hFFFF_FFEC);

    // mem stall from T+30 to T+36 during a mul
    set_op(2'b10, F_MUL, 0, 5'd10, 32'h1234_5678, 5'd11, 32'h9ABC_DEF1, 0,
           5'd9, 1);
    stalls = 0;
    for (int i = 0; i < 38; i++) begin
      bus.mem_stall_i = (i >= 30 && i <= 36);
      cycle();
      if (obs_stall) stalls++;
      if (i == 36) chk("mul_held_in_done", {31'd0, bus.RegWrite_o}, 32'd0);
    end
    chk("mul_stall_product", bus.ALU_result_o, 32'h1234_5678 * 32'h9ABC_DEF1);
    bus.mem_stall_i = 0;
    set_op(2'b10, F_ADD, 0, 5'd20, 32'd1, 5'd21, 32'd1, 0, 5'd10, 1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (obs_stall) stalls++;
    end
    chk("mul_no_restart", stalls, 33);

    // mem stall with a mul in IDLE: no start, but still stalling
    set_op(2'b10, F_MUL, 0, 5'd20, 32'd3, 5'd21, 32'd5, 0, 5'd11, 1);
    bus.mem_stall_i = 1;
    cycle(); cycle();
    chk("idle_memstall_state", {30'd0, bus.mul_state_o}, 32'd0);
    bus.mem_stall_i = 0;
    for (int i = 0; i < 10; i++) cycle();

    // reset mid-multiply
    rst = 1;
    set_op(2'b00, F_ADD, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
    cycle();
    rst = 0;
    cycle();
    chk("rst_mid_mul_stall", {31'd0, obs_stall}, 32'd0);

    // randomized traffic; ID/EX holds while EX or MEM stalls
    rand_instr();
    for (int i = 0; i < 1500; i++) begin
      rand_wb();
      bus.mem_stall_i = ($urandom_range(0, 9) == 0);
      cycle();
      hold = m_stall || bus.mem_stall_i;
      if (!hold) rand_instr();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
